// File: rtl/serial_tx_pkg.sv
// serial_pkg: line states and line levels shared by the serial transmitter and the future receiver
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts the clocks of one serial bit and flags the last one
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [TW-1:0] count;

    assign tick = count == TW'(CLKS_PER_BIT - 1);

    // wrap on the last clock of a bit so every state change starts a fresh bit at 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else
            count <= (restart || tick) ? '0 : count + TW'(1);
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: valid/ready word in, start + LSB-first data (+ even parity with SERIAL_TX_PARITY_EN) + stop bit out
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             txd,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    tx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [IW-1:0]    idx, idx_next;
    logic             txd_next;
    logic             tick;
`ifdef SERIAL_TX_PARITY_EN
    logic             par, par_next;
`endif

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .restart(state == IDLE),
        .tick   (tick)
    );

    assign ready = (state == IDLE) && !reset;

    // next state, shifter and line level; txd is computed from the next state so the pin is a plain flop
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        idx_next   = idx;
`ifdef SERIAL_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    state_next = START;
                    shreg_next = data;
`ifdef SERIAL_TX_PARITY_EN
                    par_next   = ^data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (idx == IW'(WIDTH - 1))
`ifdef SERIAL_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    else
                        idx_next = idx + IW'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: state_next = tick ? STOP : PARITY;
`endif
            STOP: state_next = tick ? IDLE : STOP;
            default: state_next = IDLE;
        endcase
        txd_next = (state_next == START) ? START_LEVEL :
                   (state_next == DATA)  ? shreg_next[0] :
                   (state_next == IDLE)  ? IDLE_LEVEL : STOP_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
        if (state_next == PARITY)
            txd_next = par_next;
`endif
    end

    // state and registered line outputs; reset drops any partial frame and parks the line high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            txd   <= IDLE_LEVEL;
            busy  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            shreg <= shreg_next;
            idx   <= idx_next;
            txd   <= txd_next;
            busy  <= state_next != IDLE;
`ifdef SERIAL_TX_PARITY_EN
            par   <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx; frame layout follows SERIAL_TX_PARITY_EN when defined
module tb_serial_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB  = W + 3;
`else
    localparam int NB  = W + 2;
`endif
    localparam int FL  = NB * CPB;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] data  = '0;
    logic         ready, txd, busy;

    always #5 clk = ~clk;

    serial_tx #(
        .WIDTH(W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock(clk),
        .reset(reset),
        .data (data),
        .valid(valid),
        .ready(ready),
        .txd  (txd),
        .busy (busy)
    );

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] cur;
    bit            active = 0;
    bit            bogus  = 0;
    int            cnt    = 0;

    always @(posedge clk) cyc++;

    // line levels of one frame, index = bit slot in transmission order
    function automatic logic [NB-1:0] frame_of(input logic [W-1:0] w);
        logic [NB-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < W; i++) f[i+1] = w[i];
`ifdef SERIAL_TX_PARITY_EN
        f[W+1] = ^w;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // monitor: frames start when the idle line drops; each cycle of a frame is checked against the popped expectation
    always @(negedge clk) begin
        if (reset) begin
            active = 0;
            bogus  = 0;
            exp_q.delete();
        end else begin
            if (!active && txd === 1'b0) begin
                check(exp_q.size() != 0, "unexpected_frame", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    cur   = exp_q.pop_front();
                    bogus = 0;
                end else begin
                    bogus = 1;
                end
                active = 1;
                cnt    = 0;
            end else if (!active) begin
                check({txd, busy, ready} === 3'b101, "idle_line", 32'({txd, busy, ready}), 32'b101);
            end
            if (active) begin
                if (!bogus)
                    check({txd, busy, ready} === {cur[cnt/CPB], 2'b10}, "frame_cycle",
                          32'({txd, busy, ready}), 32'({cur[cnt/CPB], 2'b10}));
                cnt++;
                if (cnt == FL) begin
                    active = 0;
                    bogus  = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit hold);
        int n = 0;
        @(negedge clk);
        valid = 1'b1;
        data  = w;
        while (ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            check(0, "ready_timeout", 32'(ready), 32'd1);
            valid = 1'b0;
            return;
        end
        exp_q.push_back(frame_of(w));
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        data = W'($urandom);
        if (!hold) valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((active || exp_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n == 2000) check(0, "idle_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic reset_mid(input int n);
        send(8'hA5, 0);
        repeat (n) @(posedge clk);
        #3 reset = 1'b1;
        #1 check({txd, ready, busy} === 3'b100, "reset_mid", 32'({txd, ready, busy}), 32'b100);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check({txd, ready, busy} === 3'b110, "post_reset", 32'({txd, ready, busy}), 32'b110);
        repeat (2 * FL) @(negedge clk);
    endtask

    initial begin
        #1900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        bit hold;
        #1 reset = 1'b1;
        #1 check({txd, ready, busy} === 3'b100, "reset_state", 32'({txd, ready, busy}), 32'b100);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1 check({txd, ready, busy} === 3'b110, "released", 32'({txd, ready, busy}), 32'b110);
        repeat (50) @(negedge clk);

        send(8'hA5, 0);
        wait_idle();

        send(8'h07, 1);
        a1 = acc_cyc;
        send(8'hFF, 0);
        check(acc_cyc - a1 == FL + 1, "b2b_gap", 32'(acc_cyc - a1), 32'(FL + 1));
        wait_idle();

        send(8'hA5, 0);
        repeat (10) @(negedge clk);
        valid = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        valid = 1'b0;
        wait_idle();
        repeat (FL) @(negedge clk);

        send(8'h01, 0);
        wait_idle();

        reset_mid(15);
        reset_mid(9);

        for (int i = 0; i < 20; i++) begin
            hold = (i < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            send(W'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        valid = 1'b0;
        wait_idle();
        check(exp_q.size() == 0 && !active, "queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out asynchronous transmitter, the sending end of the lab serial link. It accepts a WIDTH-bit word over a valid/ready handshake. It emits the word on a single line as start bit, data bits LSB first, optional parity bit, then stop bit, each held for CLKS_PER_BIT clocks. Its output is sampled by the enable-gated flip-flop receive path at the far end of the link.

Parameters:
WIDTH, 8, data bits per frame (1..16)
CLKS_PER_BIT, 16, clock cycles per serial bit (>= 2)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous active-high reset
data  input  WIDTH  word to send, sampled only on acceptance
valid  input  1  data is valid
ready  output  1  transmitter can accept a word this cycle
txd  output  1  serial line, idles high
busy  output  1  frame in progress (start through stop bit)

Behaviour:
- Interface: one clock `clock`; reset `reset` is asynchronous and active-high.
- Reset values (immediate, no clock edge needed): state=IDLE, txd=1, busy=0, ready=0 while reset high. Bit counter=0, shift register=0.
- ready is 1 exactly when state==IDLE and reset is low. It is combinational from state.
- Acceptance: valid && ready at a posedge. On that edge:
  - data is loaded into the shift register.
  - state goes to START, txd register goes to 0, busy goes to 1.
- valid while not ready is ignored. data may change freely after acceptance.
- States and transitions:
  - IDLE: if valid, go to START; otherwise stay in IDLE.
  - START: txd=0. After CLKS_PER_BIT cycles, go to DATA with bit index 0.
  - DATA: txd=shreg[0]. After CLKS_PER_BIT cycles, shift right. If index==WIDTH-1, go to PARITY (feature on) or STOP; otherwise increment the index.
  - PARITY: txd=parity bit, held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: txd=1, held CLKS_PER_BIT cycles, then go to IDLE with busy=0.
- Bit timer: counts 0..CLKS_PER_BIT-1. It restarts at 0 on every state change, so no bit is stretched or shortened.
- Timing:
  - txd goes low on the acceptance edge (1-cycle latency from valid sampled).
  - Frame length is (WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
  - Back-to-back: with valid held high, the next start bit begins exactly 1 cycle after the stop bit ends. That cycle is spent in IDLE with ready=1 and txd=1.
- txd is a registered output, glitch-free.
- Reset mid-frame: line returns high immediately and the partial frame is discarded. No retransmission.
- Counter widths: timer is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(WIDTH) bits (min 1). No overflow is possible given the terminal-count compares.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: PARITY state is included. Parity bit is even parity, the XOR of the word captured at acceptance, sent after the last data bit.
- Undefined: PARITY state and parity logic are absent; DATA goes straight to STOP.

Decomposition:
- Package serial_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
  - Shared with the future receiver.
- One sub-module, bit_timer: parameter CLKS_PER_BIT, inputs clock/reset/restart, output tick (last cycle of a bit). serial_tx instantiates it once.

Test Plan:
- Reset with WIDTH=8, CLKS_PER_BIT=4, valid=0 -> txd=1, ready=1, busy=0; no change over 50 cycles.
- Send 8'hA5 (parity off) -> 40 cycles of txd, 4 cycles per level, in order: 0,1,0,1,0,0,1,0,1,1. busy=1 throughout; ready returns 1 after cycle 40.
- Send 8'h07 then 8'hFF with valid held high -> two 40-cycle frames separated by exactly 1 idle-high cycle. The second frame's data bits are all 1.
- valid pulsed during a frame with data=8'h00 -> ignored; the current frame completes unchanged and no second frame is sent.
- Assert reset at cycle 15 of the 8'hA5 frame -> txd=1 and ready=0 in the same cycle; after release, ready=1 and txd stays 1.
- SERIAL_TX_PARITY_EN defined, send 8'hA5 then 8'h01 -> 44-cycle frames. Parity bit is 0 for 8'hA5 and 1 for 8'h01.
